// File: rtl/fb_pkg.sv
// Frame-buffer constants and types shared by the display reader and the
// capture writer (1 bpp, 16 pixels per SPRAM word, pixel 0 in bit 0).
package fb_pkg;

  localparam int FB_WIDTH       = 640;
  localparam int FB_HEIGHT      = 480;
  localparam int PIX_PER_WORD   = 16;
  localparam int FB_FRAME_WORDS = FB_WIDTH * FB_HEIGHT / PIX_PER_WORD;

  // SPRAM block select lives in the top two word-address bits.
  localparam int BLK_SEL_MSB = 15;
  localparam int BLK_SEL_LSB = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_STREAM,
    ST_DRAIN
  } fb_state_e;

endpackage

// File: rtl/fb_pixel_reader_if.sv
// Shared-SPRAM read port: request/grant handshake plus read data.
interface fb_pixel_reader_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_gnt;
  logic [PIX_PER_WORD-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_gnt, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_gnt, output mem_rdata);
endinterface

// File: rtl/fb_word_fifo.sv
// Two-entry word FIFO holding prefetched frame words ahead of the pixel path.
module fb_word_fifo
  import fb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [PIX_PER_WORD-1:0] din_i,
  input  logic                    pop_i,
  output logic [1:0]              count_o,
  output logic [PIX_PER_WORD-1:0] head_o
);

  logic [PIX_PER_WORD-1:0] mem_q [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;
  logic                    do_push, do_pop;

  // Qualify push/pop: pop needs data, push needs space unless a pop frees it.
  // NOTE: every always_comb output is assigned before any condition so no latch is inferred.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
  end

  // Word storage; contents are only meaningful below count_q.
  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fb_pixel_reader.sv
// Streams 1-bpp frame-buffer words out one pixel per VGA active cycle,
// prefetching up to two words through a shared SPRAM request/grant port.
module fb_pixel_reader
  import fb_pkg::*;
#(
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int ADDR_W      = 16,
  parameter int RD_LATENCY  = 1   // 1 or 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              frame_sync_i,
  input  logic              pix_req_i,
  fb_pixel_reader_if.master mem,
  output logic              pix_out_o,
  output logic              pix_out_valid_o,
  output logic              underrun_o,
  output logic              frame_done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  fb_state_e               state_q, state_d;
  logic                    req_q, req_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    done_q, done_d;
  logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
  logic [3:0]              bit_ptr_q, bit_ptr_d;
  logic                    pix_q, pix_d;
  logic                    pix_vld_q, pix_vld_d;
  logic                    underrun_q, underrun_d;

  logic                    clear, fire, last_fire, push, pop, serve;
  logic [1:0]              fifo_count, inflight;
  logic [2:0]              backlog;
  logic [PIX_PER_WORD-1:0] head_word;

  fb_word_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear),
    .push_i  (push),
    .din_i   (mem.mem_rdata),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (head_word)
  );

  // Next state, fetch control and pixel path.
  always_comb begin
    // Disable or a new frame throws away buffered and in-flight words.
    clear     = !enable_i || frame_sync_i;
    fire      = req_q && mem.mem_gnt;
    last_fire = fire && (addr_q == LAST_ADDR);
    push      = pipe_q[RD_LATENCY-1] && !clear;
    serve     = pix_req_i && !clear && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
    pop       = serve && (bit_ptr_q == 4'd15) && (fifo_count != 2'd0);

    inflight = 2'd0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 2'(pipe_q[i]);

    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (frame_sync_i) begin
      state_d = ST_PRELOAD;
    end else begin
      case (state_q)
        // Short frames may be fully fetched before two words are buffered.
        ST_PRELOAD: if ((fifo_count == 2'd2) || (done_q && inflight == 2'd0)) state_d = ST_STREAM;
        ST_STREAM:  if (done_q || last_fire) state_d = ST_DRAIN;
        default:    state_d = state_q;
      endcase
    end

    done_d = clear ? 1'b0 : (done_q || last_fire);
    addr_d = clear ? '0 : (fire ? addr_q + ADDR_W'(1) : addr_q);

    pipe_d[0] = fire;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (clear) pipe_d = '0;

    // Words committed after this edge: buffered + returning + requested - popped.
    backlog = 3'(fifo_count) + 3'(inflight) + 3'(req_q) - 3'(pop);
    req_d   = !clear && ((req_q && !fire) ||
              (((state_d == ST_PRELOAD) || (state_d == ST_STREAM)) && !done_d && (backlog < 3'd2)));

    // Pointer advances even when starved so the raster stays aligned.
    pix_d      = 1'b0;
    pix_vld_d  = pix_req_i;
    bit_ptr_d  = clear ? 4'd0 : bit_ptr_q;
    underrun_d = underrun_q;
    if (serve) begin
      bit_ptr_d = bit_ptr_q + 4'd1;
      if (fifo_count != 2'd0) pix_d = head_word[bit_ptr_q];
      else                    underrun_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      pipe_q     <= '0;
      bit_ptr_q  <= 4'd0;
      pix_q      <= 1'b0;
      pix_vld_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      pipe_q     <= pipe_d;
      bit_ptr_q  <= bit_ptr_d;
      pix_q      <= pix_d;
      pix_vld_q  <= pix_vld_d;
      underrun_q <= underrun_d;
    end
  end

  assign mem.mem_req     = req_q;
  assign mem.mem_addr    = addr_q;
  assign pix_out_o       = pix_q;
  assign pix_out_valid_o = pix_vld_q;
  assign underrun_o      = underrun_q;
  assign frame_done_o    = done_q;

endmodule
